pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage 64-bit ARM pipeline. Drives the write enables and bubble/flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three conditions in fixed priority: multi-cycle data-memory waits (whole-pipeline freeze), load-use hazards (one-bubble stall), and branches taken in ID (IF/ID flush).

## Interface
Parameters:
- MEM_TIMEOUT, default 16: maximum MEM_WAIT cycles before forced release; legal range 1..255.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; one clock domain (clk).
- id_rn, id_rm  in  5 each  source register numbers of the instruction in ID.
- id_uses_rn, id_uses_rm  in  1 each  the ID instruction actually reads that operand.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_memread  in  1  the EX instruction is a load (LDUR).
- br_taken_id  in  1  branch resolved taken in ID this cycle.
- mem_req  in  1  MEM stage issues a data-memory access this cycle.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_we, ifid_we, idex_we, exmem_we, memwb_we  out  1 each  register write enables.
- ifid_flush  out  1  load NOP into IF/ID.
- idex_bubble  out  1  clear control bits (RegWrite, MemWrite, branch) into ID/EX.
- mem_err  out  1  sticky flag: a memory access timed out.
- stall_cycles  out  32  performance count (see Configuration).

## Operation
- FSM states: BOOT, RUN, MEM_WAIT.
- BOOT: entered on reset. All *_we = 0, ifid_flush = 1, idex_bubble = 1. Transitions to RUN unconditionally after one clk edge.
- RUN: default; all *_we = 1 unless one of the conditions below applies.
- Freeze. Condition: (RUN and mem_req and !mem_ready) or (MEM_WAIT and !mem_ready).
  - All five *_we = 0; ifid_flush = 0; idex_bubble = 0.
  - RUN enters MEM_WAIT on the next edge.
- MEM_WAIT exit:
  - mem_ready = 1: no freeze this cycle, all *_we = 1, next state RUN.
  - Wait counter reaches MEM_TIMEOUT: treated as ready for enables. mem_err is set (sticky until reset) and next state is RUN.
- Load-use stall. Condition: RUN, no freeze, ex_memread = 1, ex_rd != 31, and (id_uses_rn and id_rn == ex_rd) or (id_uses_rm and id_rm == ex_rd).
  - pc_we = 0, ifid_we = 0, idex_bubble = 1.
  - exmem_we = memwb_we = 1.
  - Register 31 (XZR) never creates a hazard.
- Branch flush. Condition: RUN, no freeze, no load-use, br_taken_id = 1.
  - ifid_flush = 1; all *_we = 1.
  - During a load-use stall, br_taken_id is ignored: the branch is the stalled instruction and re-evaluates next cycle.
- Priority: BOOT > freeze > load-use > branch flush.
- Wait counter: 8 bits.
  - Cleared on entry to MEM_WAIT; increments each MEM_WAIT cycle.
  - Timeout compare is ==, so the count never wraps.

## Timing
- Freeze, load-use, flush and enable outputs are combinational from the current state and inputs, for same-cycle effect.
- FSM state, wait counter, mem_err and stall_cycles are registered.
- Reset values: state = BOOT, wait counter = 0, mem_err = 0, stall_cycles = 0. During reset, outputs equal the BOOT values.
- Reset asserted mid-MEM_WAIT: the block returns immediately to BOOT and mem_err clears.
- Load-use stall length is exactly 1 cycle: the next cycle the load has moved to MEM, and forwarding covers it.
- mem_ready in the same cycle as mem_req: no freeze and no MEM_WAIT entry.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cycles increments by 1 on every cycle where pc_we = 0 and state != BOOT.
  - Saturates at 32'hFFFF_FFFF.
- HAZARD_PERF_CNT_EN undefined: the counter logic is absent and stall_cycles is tied to 0. The port is kept so the interface is unchanged.

## Test plan
- Reset release → one BOOT cycle with all *_we = 0, ifid_flush = 1, idex_bubble = 1; then RUN with all *_we = 1.
- Load-use: ex_memread = 1, ex_rd = 5, id_rn = 5, id_uses_rn = 1 → pc_we = ifid_we = 0, idex_bubble = 1 for 1 cycle. The same stimulus with ex_rd = id_rn = 31 → no stall.
- mem_req = 1, mem_ready low for 3 cycles, then high → all *_we = 0 for 3 cycles; release on the 4th cycle; mem_err stays 0.
- mem_ready held low with MEM_TIMEOUT = 4 → forced release after 4 MEM_WAIT cycles; mem_err = 1 and stays 1 until reset.
- Load-use and br_taken_id asserted together → stall only, ifid_flush = 0. The next cycle, br_taken_id alone → ifid_flush = 1.
- With HAZARD_PERF_CNT_EN: 1 load-use stall plus a 3-cycle memory wait → stall_cycles = 4. Without the macro: stall_cycles = 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control signal bundle between the pipeline datapath (master) and the
// stall/flush sequencer (slave).
interface pipeline_hazard_ctrl_if;
  logic [4:0]  id_rn;
  logic [4:0]  id_rm;
  logic        id_uses_rn;
  logic        id_uses_rm;
  logic [4:0]  ex_rd;
  logic        ex_memread;
  logic        br_taken_id;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_we;
  logic        ifid_we;
  logic        idex_we;
  logic        exmem_we;
  logic        memwb_we;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        mem_err;
  logic [31:0] stall_cycles;

  modport master (
    output id_rn, id_rm, id_uses_rn, id_uses_rm, ex_rd, ex_memread, br_taken_id,
           mem_req, mem_ready,
    input  pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_bubble,
           mem_err, stall_cycles
  );

  modport slave (
    input  id_rn, id_rm, id_uses_rn, id_uses_rm, ex_rd, ex_memread, br_taken_id,
           mem_req, mem_ready,
    output pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_bubble,
           mem_err, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory freeze > load-use > branch flush.
// Optional stall-cycle performance counter enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input logic                   clk,
  input logic                   reset,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {StBoot, StRun, StMemWait} state_e;

  localparam logic [7:0] TimeoutCnt = 8'(MEM_TIMEOUT);
  localparam logic [4:0] RegXzr     = 5'd31;

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_err_q, mem_err_d;

  logic pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic ifid_flush, idex_bubble;
  logic load_use, timed_out, freeze;

  // XZR reads as zero, so a load targeting it never feeds a consumer.
  assign load_use = hz.ex_memread && (hz.ex_rd != RegXzr) &&
                    ((hz.id_uses_rn && (hz.id_rn == hz.ex_rd)) ||
                     (hz.id_uses_rm && (hz.id_rm == hz.ex_rd)));

  assign timed_out = (state_q == StMemWait) && (wait_cnt_q == TimeoutCnt);

  assign freeze = ((state_q == StRun) && hz.mem_req && !hz.mem_ready) ||
                  ((state_q == StMemWait) && !hz.mem_ready && !timed_out);

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_err_d   = mem_err_q;
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    idex_we     = 1'b1;
    exmem_we    = 1'b1;
    memwb_we    = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;

    unique case (state_q)
      StBoot: begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_we     = 1'b0;
        exmem_we    = 1'b0;
        memwb_we    = 1'b0;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        state_d     = StRun;
      end
      StRun: begin
        if (freeze) begin
          pc_we      = 1'b0;
          ifid_we    = 1'b0;
          idex_we    = 1'b0;
          exmem_we   = 1'b0;
          memwb_we   = 1'b0;
          state_d    = StMemWait;
          wait_cnt_d = '0;
        end else if (load_use) begin
          // Branch in ID is the stalled instruction; it re-resolves next cycle.
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_bubble = 1'b1;
        end else if (hz.br_taken_id) begin
          ifid_flush = 1'b1;
        end
      end
      StMemWait: begin
        if (freeze) begin
          pc_we      = 1'b0;
          ifid_we    = 1'b0;
          idex_we    = 1'b0;
          exmem_we   = 1'b0;
          memwb_we   = 1'b0;
          wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
          state_d = StRun;
          // A completion landing on the timeout cycle is a real completion, not an error.
          if (timed_out && !hz.mem_ready) begin
            mem_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = StBoot;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StBoot;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign hz.pc_we       = pc_we;
  assign hz.ifid_we     = ifid_we;
  assign hz.idex_we     = idex_we;
  assign hz.exmem_we    = exmem_we;
  assign hz.memwb_we    = memwb_we;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_bubble = idex_bubble;
  assign hz.mem_err     = mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (!pc_we && (state_q != StBoot) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign hz.stall_cycles = stall_cnt_q;
`else
  assign hz.stall_cycles = '0;
`endif

endmodule
